// File: rtl/bram_stream_pkg.sv
// Shared types and defaults for the block-RAM stream reader.
package bram_stream_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Small synchronous FIFO used as the output buffer of the stream reader.
// Power-of-two depth, so the pointers wrap for free. The head entry is
// read straight from storage, which keeps it stable until it is popped.
module stream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; push and pop may happen together at any fill level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side client for one block-RAM port: sweeps an address range on
// command and presents the words as a valid/ready stream with a last flag.
// A read is only issued when the FIFO is guaranteed to have room for it
// once the RAM's one-cycle latency has elapsed, so backpressure never drops data.
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [ADDR_W:0]   remaining;
    logic              pipe_valid;
    logic              pipe_last;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              pop;
    logic              last_pop;

    assign bram_we  = 1'b0;
    assign bram_din = '0;

    // Words already buffered plus the one possibly still in the RAM pipeline.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pipe_valid};
    assign issue     = (state == ISSUE) && !fifo_full
                       && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

    assign m_valid           = !fifo_empty;
    assign {m_last, m_data}  = fifo_head;
    assign pop               = m_valid && m_ready;
    assign last_pop          = pop && m_last;

    stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_valid),
        .push_data ({pipe_last, bram_dout}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Command FSM: address sweep, read-pipeline tracking, busy and done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            bram_addr  <= '0;
            remaining  <= '0;
            pipe_valid <= 1'b0;
            pipe_last  <= 1'b0;
        end else begin
            done       <= 1'b0;
            pipe_valid <= issue;
            if (issue) begin
                pipe_last <= (remaining == (ADDR_W + 1)'(1));
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state     <= ISSUE;
                            busy      <= 1'b1;
                            bram_addr <= base_addr;
                            remaining <= len;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        bram_addr <= bram_addr + ADDR_W'(1);
                        remaining <= remaining - (ADDR_W + 1)'(1);
                        if (remaining == (ADDR_W + 1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a behavioural RAM model behind the read
// port, a table of short commands, and hand-written multi-cycle sequences.
module tb_bram_stream_reader;
    import bram_stream_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [13:0] base_addr;
    logic [14:0] len;
    logic        busy;
    logic        done;
    logic [13:0] bram_addr;
    logic        bram_we;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready;

    logic [31:0] ram [16384];

    int total = 0;
    int bad   = 0;

    fifo_entry_t expq[$];

    typedef struct {
        logic [13:0]       base;
        logic [14:0]       len;
        int                n;
        logic [3:0][31:0]  d;
        int                done_cyc;
    } vec_t;

    vec_t vecs[4];

    bram_stream_reader #(
        .ADDR_W     (14),
        .DATA_W     (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_we   (bram_we),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM read port model with one cycle of read latency.
    always @(posedge clk) begin
        bram_dout <= ram[bram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Present a command for one cycle; returns in the cycle after start was sampled.
    task automatic applyStimulus(input logic [13:0] b, input logic [14:0] l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        step();
        start = 1'b0;
    endtask

    // Follow a command to its done pulse, checking every presented beat against expq.
    task automatic collectBeats(input string tag, input int ready_mode,
                                input int restart_cyc, input int exp_done_cyc);
        int idx;
        int cyc;
        int first_cyc;
        int max_cnt;
        bit finished;
        idx = 0;
        cyc = 1;
        first_cyc = -1;
        max_cnt = 0;
        finished = 1'b0;
        while (!finished && cyc < 300) begin
            if (ready_mode == 0) begin
                m_ready = 1'b1;
            end else if (cyc >= 5 && cyc < 15) begin
                m_ready = 1'b0;
            end else begin
                m_ready = 1'($urandom_range(0, 1));
            end
            start = (cyc == restart_cyc);
            if (start) begin
                base_addr = 14'h3000;
                len       = 15'd5;
            end
            if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
            if (done) begin
                finished = 1'b1;
                checkOutput({tag, "_beats"}, 32'(idx), 32'(expq.size()));
                checkOutput({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
                if (exp_done_cyc > 0) checkOutput({tag, "_done_cyc"}, 32'(cyc), 32'(exp_done_cyc));
            end else begin
                checkOutput({tag, "_busy"}, {31'd0, busy}, {31'd0, expq.size() != 0});
                if (m_valid) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    if (idx < expq.size()) begin
                        checkOutput({tag, "_data"}, m_data, expq[idx].data);
                        checkOutput({tag, "_last"}, {31'd0, m_last}, {31'd0, expq[idx].last});
                        if (m_ready) idx++;
                    end else begin
                        checkOutput({tag, "_extra_beat"}, {31'd0, m_valid}, 32'd0);
                    end
                end
                step();
                cyc++;
            end
        end
        start = 1'b0;
        if (!finished) checkOutput({tag, "_timeout"}, {31'd0, done}, 32'd1);
        if (ready_mode == 0 && expq.size() > 0) checkOutput({tag, "_first_cyc"}, 32'(first_cyc), 32'd3);
        checkOutput({tag, "_fifo_bound"}, {31'd0, max_cnt <= 4}, 32'd1);
        m_ready = 1'b1;
        step();
        checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_idle_valid"}, {31'd0, m_valid}, 32'd0);
    endtask

    task automatic loadExpected(input logic [13:0] b, input int n);
        fifo_entry_t e;
        expq.delete();
        for (int i = 0; i < n; i++) begin
            e.data = ram[b + 14'(i)];
            e.last = (i == n - 1);
            expq.push_back(e);
        end
    endtask

    // Main sequence: reset checks, command table, then corner-case sequences.
    initial begin
        fifo_entry_t e;
        int hs;
        int ghost;

        for (int i = 0; i < 16384; i++) ram[i] = 32'hC000_0000 | 32'(i);
        ram[14'h0010] = 32'hA0;
        ram[14'h0011] = 32'hA1;
        ram[14'h0012] = 32'hA2;
        ram[14'h0013] = 32'hA3;
        ram[14'h3FFE] = 32'd1;
        ram[14'h3FFF] = 32'd2;
        ram[14'h0000] = 32'd3;
        ram[14'h0001] = 32'd4;

        vecs[0] = '{base: 14'h0010, len: 15'd4, n: 4, d: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, done_cyc: 7};
        vecs[1] = '{base: 14'h3FFE, len: 15'd4, n: 4, d: {32'd4, 32'd3, 32'd2, 32'd1}, done_cyc: 7};
        vecs[2] = '{base: 14'h0000, len: 15'd0, n: 0, d: '0, done_cyc: 1};
        vecs[3] = '{base: 14'h0011, len: 15'd1, n: 1, d: {32'd0, 32'd0, 32'd0, 32'hA1}, done_cyc: 4};

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b1;
        step();
        step();
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_addr", {18'd0, bram_addr}, 32'd0);
        checkOutput("rst_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_data", m_data, 32'd0);
        checkOutput("rst_last", {31'd0, m_last}, 32'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            expq.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                e.data = vecs[v].d[i];
                e.last = (i == vecs[v].n - 1);
                expq.push_back(e);
            end
            applyStimulus(vecs[v].base, vecs[v].len);
            if (vecs[v].n > 0) checkOutput($sformatf("vec%0d_addr0", v), {18'd0, bram_addr}, {18'd0, vecs[v].base});
            collectBeats($sformatf("vec%0d", v), 0, -1, vecs[v].done_cyc);
        end

        // Backpressure: long stall then pseudo-random ready.
        loadExpected(14'h0100, 16);
        applyStimulus(14'h0100, 15'd16);
        collectBeats("stall16", 1, -1, -1);

        // A second start while busy must be ignored.
        loadExpected(14'h0200, 6);
        applyStimulus(14'h0200, 15'd6);
        collectBeats("restart", 0, 2, 9);

        // Reset after three beats of an eight-word command.
        applyStimulus(14'h0020, 15'd8);
        hs = 0;
        for (int c = 0; c < 50 && hs < 3; c++) begin
            m_ready = 1'b1;
            if (m_valid) begin
                checkOutput("rst_mid_data", m_data, 32'hC000_0020 + 32'(hs));
                hs++;
            end
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("rst_mid_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mid_done", {31'd0, done}, 32'd0);
        ghost = 0;
        repeat (8) begin
            if (done || m_valid) ghost++;
            step();
        end
        checkOutput("rst_mid_quiet", 32'(ghost), 32'd0);

        expq.delete();
        e.data = 32'd3; e.last = 1'b0; expq.push_back(e);
        e.data = 32'd4; e.last = 1'b1; expq.push_back(e);
        applyStimulus(14'h0000, 15'd2);
        collectBeats("post_rst", 0, -1, 5);

        checkOutput("bram_we", {31'd0, bram_we}, 32'd0);
        checkOutput("bram_din", bram_din, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
